// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and
// baud-rate constants used by the RX, TX and baud generator.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int BPS_DIV        = 5207;
  localparam int BPS_MID        = 2603;

endpackage

// File: rtl/uart_rx_sync.sv
// rxd synchronizer plus falling-edge detector.
// Ports: clk, rst (sync, active-high), rxd (async line),
//        line_s (synchronized line), line_fall (high->low pulse).
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic line_s,
  output logic line_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_d;

  // Fill with 1s on reset so an idle line never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
      r_d    <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
      r_d    <= r_sync[SYNC_STAGES-1];
    end
  end

  assign line_s    = r_sync[SYNC_STAGES-1];
  assign line_fall = r_d & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-edge detect, mid-bit sampling, 8N1.
// Ports: clk, rst, rxd, bps_tick in; bps_start, rx_data, rx_valid,
//        frame_err, busy out.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 bps_tick,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  state_t               r_state;
  state_t               w_next;
  logic                 w_line;
  logic                 w_fall;
  logic [CW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .line_s   (w_line),
    .line_fall(w_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_fall) w_next = START;
      // A high line at mid start bit is a glitch, not a frame.
      START: if (bps_tick) w_next = w_line ? IDLE : DATA;
      DATA:  if (bps_tick && r_bit_cnt == LAST_BIT) w_next = STOP;
      STOP:  if (bps_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Dropping in IDLE clears the baud counter so it
  // realigns on every start edge.
  always_comb begin
    bps_start = (r_state != IDLE);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        START: if (bps_tick) r_bit_cnt <= '0;
        DATA: begin
          if (bps_tick) begin
            // LSB arrives first, so shift right from the MSB side.
            r_shift   <= {w_line, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bps_tick) begin
            if (w_line) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a reduced-divider
// baud generator (16 clk per bit, tick at count 7).
module tb_uart_rx_ctrl;

  localparam int TB_DIV   = 15;
  localparam int TB_MID   = 7;
  localparam int BIT_CLKS = TB_DIV + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       bps_tick;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .bps_tick (bps_tick),
    .bps_start(bps_start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // Baud generator model: counter held clear while bps_start is low.
  logic [4:0] bcnt;
  always_ff @(posedge clk) begin
    if (!bps_start) bcnt <= '0;
    else bcnt <= (bcnt == 5'(TB_DIV)) ? 5'd0 : bcnt + 5'd1;
  end
  assign bps_tick = bps_start && (bcnt == 5'(TB_MID));

  // Observation on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_valid, n_ferr, n_both, n_wide, n_bs_fall;
  int         tick_cyc, valid_cyc, ferr_cyc, bs_fall_cyc;
  logic [7:0] cap[$];
  logic       busy_at_valid, busy_before_valid;
  logic       prev_valid, prev_ferr, prev_bs, prev_busy;

  always @(negedge clk) begin
    if (bps_tick === 1'b1) tick_cyc = cyc;
    if (rx_valid === 1'b1) begin
      n_valid++;
      valid_cyc = cyc;
      cap.push_back(rx_data);
      busy_at_valid = busy;
      busy_before_valid = prev_busy;
    end
    if (frame_err === 1'b1) begin
      n_ferr++;
      ferr_cyc = cyc;
    end
    if (rx_valid === 1'b1 && frame_err === 1'b1) n_both++;
    if ((rx_valid === 1'b1 && prev_valid === 1'b1) ||
        (frame_err === 1'b1 && prev_ferr === 1'b1)) n_wide++;
    if (prev_bs === 1'b1 && bps_start === 1'b0) begin
      n_bs_fall++;
      bs_fall_cyc = cyc;
    end
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
    prev_bs    = bps_start;
    prev_busy  = busy;
  end

  task automatic clear_obs();
    n_valid = 0; n_ferr = 0; n_both = 0; n_wide = 0; n_bs_fall = 0;
    tick_cyc = -100; valid_cyc = -1; ferr_cyc = -1; bs_fall_cyc = -1;
    cap.delete();
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clks(BIT_CLKS);
    end
    rxd = stop;
    wait_clks(BIT_CLKS);
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    wait_clks(3);
    n_checks += 5;
    if (bps_start !== 1'b0) begin n_errors++; $display("FAIL reset_bps_start: got %b expected 0", bps_start); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    if (rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    rst = 1'b0;
    wait_clks(20);
  endtask

  task automatic test_good_frame();
    clear_obs();
    send_frame(8'hA5, 1'b1);
    wait_clks(20);
    n_checks += 8;
    if (n_valid != 1) begin n_errors++; $display("FAIL good_valid_count: got %0d expected 1", n_valid); end
    if (rx_data !== 8'hA5) begin n_errors++; $display("FAIL good_rx_data: got %h expected a5", rx_data); end
    if (n_ferr != 0) begin n_errors++; $display("FAIL good_ferr_count: got %0d expected 0", n_ferr); end
    if (valid_cyc != tick_cyc + 1) begin n_errors++; $display("FAIL good_latency: got %0d expected %0d", valid_cyc, tick_cyc + 1); end
    if (n_wide != 0) begin n_errors++; $display("FAIL good_pulse_width: got %0d long pulses expected 0", n_wide); end
    if (busy_at_valid !== 1'b0) begin n_errors++; $display("FAIL good_busy_at_valid: got %b expected 0", busy_at_valid); end
    if (busy_before_valid !== 1'b1) begin n_errors++; $display("FAIL good_busy_before_valid: got %b expected 1", busy_before_valid); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL good_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_frame_err();
    clear_obs();
    send_frame(8'h3C, 1'b0);
    wait_clks(20);
    n_checks += 5;
    if (n_ferr != 1) begin n_errors++; $display("FAIL ferr_count: got %0d expected 1", n_ferr); end
    if (n_valid != 0) begin n_errors++; $display("FAIL ferr_valid_count: got %0d expected 0", n_valid); end
    if (rx_data !== 8'hA5) begin n_errors++; $display("FAIL ferr_rx_data_held: got %h expected a5", rx_data); end
    if (ferr_cyc != tick_cyc + 1) begin n_errors++; $display("FAIL ferr_latency: got %0d expected %0d", ferr_cyc, tick_cyc + 1); end
    if (n_both != 0 || n_wide != 0) begin n_errors++; $display("FAIL ferr_pulse_shape: got both=%0d wide=%0d expected 0 0", n_both, n_wide); end
  endtask

  task automatic test_glitch();
    clear_obs();
    rxd = 1'b0;
    wait_clks(3);
    rxd = 1'b1;
    wait_clks(30);
    n_checks += 5;
    if (n_valid != 0 || n_ferr != 0) begin n_errors++; $display("FAIL glitch_outputs: got valid=%0d ferr=%0d expected 0 0", n_valid, n_ferr); end
    if (n_bs_fall != 1) begin n_errors++; $display("FAIL glitch_start_entered: got %0d bps_start falls expected 1", n_bs_fall); end
    if (bs_fall_cyc - tick_cyc < 1 || bs_fall_cyc - tick_cyc > 2) begin n_errors++; $display("FAIL glitch_bps_drop: got %0d clks after tick expected 1..2", bs_fall_cyc - tick_cyc); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    if (bps_start !== 1'b0) begin n_errors++; $display("FAIL glitch_bps_start: got %b expected 0", bps_start); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clks(20);
    n_checks += 5;
    if (n_valid != 2) begin n_errors++; $display("FAIL b2b_valid_count: got %0d expected 2", n_valid); end
    if (cap.size() < 1 || cap[0] !== 8'h00) begin n_errors++; $display("FAIL b2b_first_byte: got %h expected 00", (cap.size() > 0) ? cap[0] : 8'hxx); end
    if (cap.size() < 2 || cap[1] !== 8'hFF) begin n_errors++; $display("FAIL b2b_second_byte: got %h expected ff", (cap.size() > 1) ? cap[1] : 8'hxx); end
    if (n_bs_fall != 2) begin n_errors++; $display("FAIL b2b_bps_gap: got %0d bps_start falls expected 2", n_bs_fall); end
    if (n_ferr != 0) begin n_errors++; $display("FAIL b2b_ferr_count: got %0d expected 0", n_ferr); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h55;
    clear_obs();
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      wait_clks(BIT_CLKS);
    end
    rxd = d[4];
    wait_clks(5);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    n_checks += 3;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (bps_start !== 1'b0) begin n_errors++; $display("FAIL midrst_bps_start: got %b expected 0", bps_start); end
    if (rx_data !== 8'h00) begin n_errors++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
    rxd = 1'b1;
    wait_clks(8 * BIT_CLKS);
    n_checks += 1;
    if (n_valid != 0 || n_ferr != 0) begin n_errors++; $display("FAIL midrst_no_output: got valid=%0d ferr=%0d expected 0 0", n_valid, n_ferr); end
    send_frame(8'h81, 1'b1);
    wait_clks(20);
    n_checks += 2;
    if (n_valid != 1) begin n_errors++; $display("FAIL midrst_next_valid: got %0d expected 1", n_valid); end
    if (rx_data !== 8'h81) begin n_errors++; $display("FAIL midrst_next_data: got %h expected 81", rx_data); end
  endtask

  task automatic test_break();
    clear_obs();
    rxd = 1'b0;
    wait_clks(12 * BIT_CLKS);
    n_checks += 4;
    if (n_ferr != 1) begin n_errors++; $display("FAIL break_ferr: got %0d expected 1", n_ferr); end
    if (n_valid != 0) begin n_errors++; $display("FAIL break_valid: got %0d expected 0", n_valid); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL break_idle: got busy=%b expected 0", busy); end
    if (n_bs_fall != 1) begin n_errors++; $display("FAIL break_no_retrigger: got %0d bps_start falls expected 1", n_bs_fall); end
    rxd = 1'b1;
    wait_clks(20);
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_good_frame();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_break();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
